// File: rtl/rv_regfile_pkg.sv
// rtl/rv_regfile_pkg.sv - shared constants and helpers for the multi-port register file
package rv_regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_REG  = 0;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rv_scoreboard.sv
// rtl/rv_scoreboard.sv - write-pending scoreboard: busy bits, claim arbitration, pending count
// Same-cycle writeback forwarding into claim_ready is enabled by REGFILE_BYPASS_EN.
module rv_scoreboard
  import rv_regfile_pkg::*;
#(
  parameter int  NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS),
  localparam int CW    = cnt_w(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             claim_valid_i,
  input  logic [AW-1:0]    claim_addr_i,
  input  logic             wb_valid_i,
  input  logic [AW-1:0]    wb_addr_i,
  output logic             claim_ready_o,
  output logic [NREGS-1:0] busy_o,
  output logic [CW-1:0]    pending_cnt_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] set_vec, clr_vec;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wb_fire, claim_busy, claim_fire, inc, dec;

  assign wb_fire = wb_valid_i && (wb_addr_i != AW'(ZERO_REG));

`ifdef REGFILE_BYPASS_EN
  assign claim_busy = busy_q[claim_addr_i] && !(wb_fire && (wb_addr_i == claim_addr_i));
`else
  assign claim_busy = busy_q[claim_addr_i];
`endif

  assign claim_ready_o = claim_valid_i && !claim_busy;
  assign claim_fire    = claim_ready_o && (claim_addr_i != AW'(ZERO_REG));

  // The set is applied after the clear so a same-address claim wins over the release.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (claim_fire) set_vec[claim_addr_i] = 1'b1;
    if (wb_fire)    clr_vec[wb_addr_i]    = 1'b1;
    busy_d = (busy_q & ~clr_vec) | set_vec;
  end

  // Count tracks the popcount incrementally: only real 0->1 and 1->0 transitions move it.
  assign inc   = claim_fire && !busy_q[claim_addr_i];
  assign dec   = wb_fire && busy_q[wb_addr_i] && !(claim_fire && (claim_addr_i == wb_addr_i));
  assign cnt_d = cnt_q + CW'(inc) - CW'(dec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o        = busy_q;
  assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/rv_regfile_mp.sv
// rtl/rv_regfile_mp.sv - NRD-read, 1-write register file with write-pending scoreboard
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to reads and claims.
module rv_regfile_mp
  import rv_regfile_pkg::*;
#(
  parameter int  XLEN  = XLEN_DEF,
  parameter int  NREGS = NREGS_DEF,
  parameter int  NRD   = 2,
  localparam int AW    = $clog2(NREGS),
  localparam int CW    = cnt_w(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic                claim_valid_i,
  input  logic [AW-1:0]       claim_addr_i,
  output logic                claim_ready_o,
  input  logic                wb_valid_i,
  input  logic [AW-1:0]       wb_addr_i,
  input  logic [XLEN-1:0]     wb_data_i,
  output logic [CW-1:0]       pending_cnt_o
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy;
  logic             wb_fire;

  assign wb_fire = wb_valid_i && (wb_addr_i != AW'(ZERO_REG));

  rv_scoreboard #(
    .NREGS(NREGS)
  ) u_scoreboard (
    .clk           (clk),
    .rst           (rst),
    .claim_valid_i (claim_valid_i),
    .claim_addr_i  (claim_addr_i),
    .wb_valid_i    (wb_valid_i),
    .wb_addr_i     (wb_addr_i),
    .claim_ready_o (claim_ready_o),
    .busy_o        (busy),
    .pending_cnt_o (pending_cnt_o)
  );

  // x0 is never written, so its entry stays at the reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else if (wb_fire) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;

    assign ra = rd_addr_i[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign hit = wb_fire && !rst && (wb_addr_i == ra);
`else
    assign hit = 1'b0;
`endif
    assign rd_data_o[i*XLEN +: XLEN] = hit ? wb_data_i : regs_q[ra];
    assign rd_busy_o[i]              = !hit && busy[ra];
  end

endmodule

// File: tb/tb_rv_regfile_mp.sv
// tb/tb_rv_regfile_mp.sv - self-checking bench for rv_regfile_mp (table vectors + random vs model)
module tb_rv_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        claim_valid, claim_ready, wb_valid;
  logic [4:0]  claim_addr, wb_addr;
  logic [31:0] wb_data;
  logic [5:0]  pending_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] reg_m  [32];
  bit          busy_m [32];

  always #5 clk = ~clk;

  rv_regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .rd_busy_o     (rd_busy),
    .claim_valid_i (claim_valid),
    .claim_addr_i  (claim_addr),
    .claim_ready_o (claim_ready),
    .wb_valid_i    (wb_valid),
    .wb_addr_i     (wb_addr),
    .wb_data_i     (wb_data),
    .pending_cnt_o (pending_cnt)
  );

  typedef struct {
    logic        rdy;
    logic [31:0] d0;
    logic        b0;
    logic [31:0] d1;
    logic        b1;
    int          cnt;
  } exp_t;

  typedef struct {
    logic        cv;
    logic [4:0]  ca;
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r0;
    logic [4:0]  r1;
    exp_t        en;
    exp_t        eb;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hit(input logic [4:0] a);
    return BYP && wb_valid && (wb_addr != 0) && (wb_addr == a);
  endfunction

  function automatic logic [31:0] m_data(input logic [4:0] a);
    if (a == 0) return 32'h0;
    return m_hit(a) ? wb_data : reg_m[a];
  endfunction

  function automatic bit m_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    return m_hit(a) ? 1'b0 : busy_m[a];
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int k = 0; k < 32; k++) c += int'(busy_m[k]);
    return c;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 32; k++) begin
      reg_m[k]  = 32'h0;
      busy_m[k] = 1'b0;
    end
  endtask

  task automatic apply(input logic cv, input logic [4:0] ca, input logic wv, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] r0, input logic [4:0] r1);
    claim_valid = cv;
    claim_addr  = ca;
    wb_valid    = wv;
    wb_addr     = wa;
    wb_data     = wd;
    rd_addr     = {r1, r0};
    #3;
  endtask

  // Clock edge: the model applies release first, then an accepted claim, so the claim wins.
  task automatic advance();
    bit acc;
    acc = claim_valid && !m_busy(claim_addr);
    @(posedge clk);
    #1;
    if (wb_valid && wb_addr != 0) begin
      reg_m[wb_addr]  = wb_data;
      busy_m[wb_addr] = 1'b0;
    end
    if (acc && claim_addr != 0) busy_m[claim_addr] = 1'b1;
  endtask

  vec_t vecs[$];

  initial begin
    exp_t e;
    vec_t v;
    rst = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int a = 0; a < 32; a++) begin
      apply(0, 0, 0, 0, 0, 5'(a), 5'(31 - a));
      chk("reset_d0", rd_data[31:0], 32'h0);
      chk("reset_d1", rd_data[63:32], 32'h0);
      chk("reset_busy", {30'h0, rd_busy}, 32'h0);
    end
    chk("reset_cnt", {26'h0, pending_cnt}, 32'h0);

    //           cv ca  wv wa  wd            r0 r1   {rdy d0 b0 d1 b1 cnt} nobyp / byp
    vecs.push_back('{1, 5, 0, 0, 32'h0,        5, 0, '{1, 32'h0, 0, 32'h0, 0, 1}, '{1, 32'h0, 0, 32'h0, 0, 1}});
    vecs.push_back('{0, 0, 0, 0, 32'h0,        5, 5, '{0, 32'h0, 1, 32'h0, 1, 1}, '{0, 32'h0, 1, 32'h0, 1, 1}});
    vecs.push_back('{0, 0, 1, 5, 32'hDEADBEEF, 5, 0, '{0, 32'h0, 1, 32'h0, 0, 0}, '{0, 32'hDEADBEEF, 0, 32'h0, 0, 0}});
    vecs.push_back('{0, 0, 0, 0, 32'h0,        5, 5, '{0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0}, '{0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0}});
    vecs.push_back('{1, 7, 0, 0, 32'h0,        7, 5, '{1, 32'h0, 0, 32'hDEADBEEF, 0, 1}, '{1, 32'h0, 0, 32'hDEADBEEF, 0, 1}});
    vecs.push_back('{0, 0, 1, 7, 32'h1234,     7, 7, '{0, 32'h0, 1, 32'h0, 1, 0}, '{0, 32'h1234, 0, 32'h1234, 0, 0}});
    vecs.push_back('{1, 3, 0, 0, 32'h0,        3, 7, '{1, 32'h0, 0, 32'h1234, 0, 1}, '{1, 32'h0, 0, 32'h1234, 0, 1}});
    vecs.push_back('{1, 3, 0, 0, 32'h0,        3, 0, '{0, 32'h0, 1, 32'h0, 0, 1}, '{0, 32'h0, 1, 32'h0, 0, 1}});
    vecs.push_back('{1, 3, 1, 3, 32'h55,       3, 3, '{0, 32'h0, 1, 32'h0, 1, 0}, '{1, 32'h55, 0, 32'h55, 0, 1}});
    vecs.push_back('{0, 0, 0, 0, 32'h0,        3, 0, '{0, 32'h55, 0, 32'h0, 0, 0}, '{0, 32'h55, 1, 32'h0, 0, 1}});
    vecs.push_back('{1, 0, 1, 0, 32'hFFFFFFFF, 0, 3, '{1, 32'h0, 0, 32'h55, 0, 0}, '{1, 32'h0, 0, 32'h55, 1, 1}});
    vecs.push_back('{0, 0, 0, 0, 32'h0,        0, 0, '{0, 32'h0, 0, 32'h0, 0, 0}, '{0, 32'h0, 0, 32'h0, 0, 1}});
    vecs.push_back('{0, 0, 1, 3, 32'h66,       3, 0, '{0, 32'h55, 0, 32'h0, 0, 0}, '{0, 32'h66, 0, 32'h0, 0, 0}});
    vecs.push_back('{0, 0, 0, 0, 32'h0,        3, 3, '{0, 32'h66, 0, 32'h66, 0, 0}, '{0, 32'h66, 0, 32'h66, 0, 0}});

    foreach (vecs[i]) begin
      v = vecs[i];
      e = BYP ? v.eb : v.en;
      apply(v.cv, v.ca, v.wv, v.wa, v.wd, v.r0, v.r1);
      chk($sformatf("vec%0d_rdy", i), {31'h0, claim_ready}, {31'h0, e.rdy});
      chk($sformatf("vec%0d_d0", i), rd_data[31:0], e.d0);
      chk($sformatf("vec%0d_b0", i), {31'h0, rd_busy[0]}, {31'h0, e.b0});
      chk($sformatf("vec%0d_d1", i), rd_data[63:32], e.d1);
      chk($sformatf("vec%0d_b1", i), {31'h0, rd_busy[1]}, {31'h0, e.b1});
      advance();
      chk($sformatf("vec%0d_cnt", i), {26'h0, pending_cnt}, 32'(e.cnt));
    end

    for (int n = 0; n < 400; n++) begin
      logic [4:0] ca, wa;
      ca = 5'($urandom_range(0, 31));
      wa = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) wa = ca;
      apply(1'($urandom_range(0, 1)), ca, ($urandom_range(0, 3) != 0), wa, $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      chk("rand_rdy", {31'h0, claim_ready}, {31'h0, claim_valid && !m_busy(claim_addr)});
      chk("rand_d0", rd_data[31:0], m_data(rd_addr[4:0]));
      chk("rand_d1", rd_data[63:32], m_data(rd_addr[9:5]));
      chk("rand_busy", {30'h0, rd_busy}, {30'h0, m_busy(rd_addr[9:5]), m_busy(rd_addr[4:0])});
      advance();
      chk("rand_cnt", {26'h0, pending_cnt}, 32'(m_cnt()));
    end

    for (int i = 1; i < 32; i++) begin
      apply(1, 5'(i), 0, 0, 0, 5'(i - 1), 5'(i - 2));
      if (i == 20) begin
        #1 rst = 1'b1;
        #1;
        chk("rst_cnt", {26'h0, pending_cnt}, 32'h0);
        chk("rst_busy", {30'h0, rd_busy}, 32'h0);
        chk("rst_d0", rd_data[31:0], 32'h0);
        chk("rst_d1", rd_data[63:32], 32'h0);
        chk("rst_rdy", {31'h0, claim_ready}, {31'h0, claim_valid});
        break;
      end
      advance();
      chk("fill_cnt", {26'h0, pending_cnt}, 32'(m_cnt()));
    end
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      apply(0, 0, 0, 0, 0, 5'(a), 5'(a));
      chk("post_rst_d", rd_data[31:0], 32'h0);
      chk("post_rst_busy", {30'h0, rd_busy}, 32'h0);
    end
    chk("post_rst_cnt", {26'h0, pending_cnt}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
